// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   STAT_W      : width of each per-requester beat statistics counter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

   localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority search.
//   valid      in  NUM_REQ  request vector
//   last_grant in  IDX_W    index granted most recently
//   found      out 1        at least one request is valid
//   next_idx   out IDX_W    first valid index searching upward from last_grant+1, with wrap
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               found,
   output logic [IDX_W-1:0]   next_idx
);

   int unsigned cand;

   // Scan from the farthest candidate to the nearest so the nearest valid one wins.
   always_comb begin
      found    = 1'b0;
      next_idx = '0;
      cand     = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = (int'(last_grant) + i) % NUM_REQ;
         if (valid[cand[IDX_W-1:0]]) begin
            found    = 1'b1;
            next_idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST beats, ends early on req_last or when the granted
// requester drops valid, and is held (without timeout) while the FIFO is full.
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/last/data    per-requester beat interface (data packed, DATA_WIDTH each)
//   req_ready              per-requester accept
//   fifo_full              FIFO back-pressure
//   fifo_cs/wr_en/data_in  FIFO write side
//   grant_id, busy         current owner and grant-active flag
//   stat_beats             per-requester saturating beat counters, only when
//                          FIFO_ARB_STATS_EN is defined
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_cs,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_beats
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic             cur_valid;
   logic             cur_last;
   logic             xfer;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid      (req_valid),
      .last_grant (last_q),
      .found      (found),
      .next_idx   (pick)
   );

   assign cur_valid = req_valid[grant_q];
   assign cur_last  = req_last[grant_q];
   assign xfer      = (state_q == GRANT) && cur_valid && !fifo_full;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               grant_d = pick;
               beat_d  = '0;
            end
         end
         GRANT: begin
            if (!cur_valid) begin
               // Dropping valid abandons the grant even while the FIFO is full.
               state_d = IDLE;
               last_d  = grant_q;
            end else if (!fifo_full) begin
               beat_d = beat_q + 1'b1;
               if (cur_last || beat_q == CNT_W'(MAX_BURST - 1)) begin
                  state_d = IDLE;
                  last_d  = grant_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      busy         = (state_q == GRANT);
      fifo_cs      = busy;
      fifo_wr_en   = xfer;
      grant_id     = grant_q;
      req_ready    = '0;
      fifo_data_in = req_data[DATA_WIDTH-1:0];
      if (busy && !fifo_full) begin
         req_ready[grant_q] = 1'b1;
      end
      for (int i = 1; i < NUM_REQ; i++) begin
         if (grant_q == IDX_W'(i)) begin
            fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef FIFO_ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      logic [STAT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (xfer && grant_q == IDX_W'(g) && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign stat_beats[g*STAT_W +: STAT_W] = cnt_q;
   end
`endif

endmodule
